// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the camera capture sequencer.
package cam_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ANALYZE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_CAM    = 2'd1;
  localparam logic [1:0] ERR_CAP_TO = 2'd2;
  localparam logic [1:0] ERR_AN_TO  = 2'd3;

  localparam int TO_W = 24;

endpackage

// File: rtl/capture_sequencer_if.sv
// Control/status bundle between software, camera reader, analyzer and the capture sequencer.
interface capture_sequencer_if #(parameter int CNT_W = 16) ();

  logic             start;
  logic             abort;
  logic             cont;
  logic             cam_done;
  logic             cam_error;
  logic             cam_init;
  logic             an_done;
  logic [2:0]       an_res;
  logic             an_init;
  logic             busy;
  logic             done;
  logic [2:0]       res;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] frame_cnt;

  modport slave (
    input  start, abort, cont, cam_done, cam_error, an_done, an_res,
    output cam_init, an_init, busy, done, res, err_code, frame_cnt
  );

  modport master (
    output start, abort, cont, cam_done, cam_error, an_done, an_res,
    input  cam_init, an_init, busy, done, res, err_code, frame_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences camera capture then analysis with per-phase watchdog, bounded capture retry,
// abort and continuous re-arm; outputs are registered alongside the state.
module capture_sequencer
  import cam_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MAX_RETRY   = 2,
  parameter int CNT_W       = 16
) (
  input logic                clk,
  input logic                rst,
  capture_sequencer_if.slave bus
);

  localparam logic [TO_W-1:0] WD_LOAD   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  state_t           state;
  logic [TO_W-1:0]  wdog;
  logic [2:0]       retry_cnt;
  logic             cam_init;
  logic             an_init;
  logic             busy;
  logic             done;
  logic [2:0]       res;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] frame_cnt;
  logic             cam_done_s;
  logic             cam_error_s;
  logic             wd_exp;

  sync_2ff u_sync_done (.clk(clk), .rst(rst), .d(bus.cam_done),  .q(cam_done_s));
  sync_2ff u_sync_err  (.clk(clk), .rst(rst), .d(bus.cam_error), .q(cam_error_s));

  // Watchdog is loaded with TIMEOUT_CYC-1 on entry, so a state lasts exactly TIMEOUT_CYC cycles.
  assign wd_exp = (wdog == '0);

  task automatic goto(input state_t s);
    state    <= s;
    wdog     <= WD_LOAD;
    cam_init <= (s == ST_CAPTURE);
    an_init  <= (s == ST_ANALYZE);
    busy     <= (s == ST_ARM) || (s == ST_CAPTURE) || (s == ST_ANALYZE);
  endtask

  task automatic retry_or_fault(input logic [1:0] code);
    err_code <= code;
    if (retry_cnt < RETRY_MAX) begin
      retry_cnt <= retry_cnt + 3'd1;
      goto(ST_ARM);
    end else begin
      goto(ST_FAULT);
    end
  endtask

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wdog      <= '0;
      retry_cnt <= '0;
      cam_init  <= 1'b0;
      an_init   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res       <= '0;
      err_code  <= ERR_NONE;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (!wd_exp) wdog <= wdog - TO_W'(1);
      if (bus.abort) begin
        goto(ST_IDLE);
      end else begin
        unique case (state)
          ST_IDLE: if (bus.start) begin
            err_code  <= ERR_NONE;
            retry_cnt <= '0;
            goto(ST_ARM);
          end
          // Previous frame status must be gone before cam_init is raised again.
          ST_ARM: begin
            if (!cam_done_s && !cam_error_s) goto(ST_CAPTURE);
            else if (wd_exp)                 retry_or_fault(ERR_CAP_TO);
          end
          ST_CAPTURE: begin
            if (cam_error_s)     retry_or_fault(ERR_CAM);
            else if (cam_done_s) goto(ST_ANALYZE);
            else if (wd_exp)     retry_or_fault(ERR_CAP_TO);
          end
          ST_ANALYZE: begin
            if (bus.an_done) begin
              res       <= bus.an_res;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + CNT_W'(1);
              goto(ST_DONE);
            end else if (wd_exp) begin
              err_code <= ERR_AN_TO;
              goto(ST_FAULT);
            end
          end
          ST_DONE: if (bus.cont || bus.start) begin
            err_code  <= ERR_NONE;
            retry_cnt <= '0;
            goto(ST_ARM);
          end
          ST_FAULT: if (bus.start) begin
            err_code  <= ERR_NONE;
            retry_cnt <= '0;
            goto(ST_ARM);
          end
          default: goto(ST_IDLE);
        endcase
      end
    end
  end

  assign bus.cam_init  = cam_init;
  assign bus.an_init   = an_init;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.res       = res;
  assign bus.err_code  = err_code;
  assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer: camera/analyzer responders plus a transaction-rule reference model.
module tb_capture_sequencer;

  localparam int TIMEOUT_CYC = 40;
  localparam int MAX_RETRY   = 2;
  localparam int CNT_W       = 4;
  localparam int SEG_LEN     = 2500;
  localparam int N_SEG       = 8;

  localparam int M_IDLE = 0, M_ARM = 1, M_CAPTURE = 2, M_ANALYZE = 3, M_DONE = 4, M_FAULT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  capture_sequencer_if #(.CNT_W(CNT_W)) bus ();

  capture_sequencer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state name, cycles spent in the current state, and status values.
  int m_st, m_cyc, m_retry, m_res, m_err, m_frames;
  bit m_done;
  bit cd_q[$];
  bit ce_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit ab, input bit ct,
                            input bit cd, input bit ce, input bit ad, input int ar);
    bit sd, se, expired, fail;
    int nx, code;
    if (r) begin
      m_st = M_IDLE; m_cyc = 0; m_retry = 0; m_res = 0; m_err = 0; m_frames = 0; m_done = 0;
      cd_q = '{1'b0, 1'b0};
      ce_q = '{1'b0, 1'b0};
      return;
    end
    // Camera status is seen two clocks after it was sampled.
    sd = cd_q.pop_front(); cd_q.push_back(cd);
    se = ce_q.pop_front(); ce_q.push_back(ce);
    m_done = 0;
    m_cyc++;
    expired = (m_cyc >= TIMEOUT_CYC);
    nx = -1; fail = 0; code = 0;
    if (ab) nx = M_IDLE;
    else begin
      case (m_st)
        M_IDLE: if (st) begin m_err = 0; m_retry = 0; nx = M_ARM; end
        M_ARM: begin
          if (!sd && !se) nx = M_CAPTURE;
          else if (expired) begin fail = 1; code = 2; end
        end
        M_CAPTURE: begin
          if (se) begin fail = 1; code = 1; end
          else if (sd) nx = M_ANALYZE;
          else if (expired) begin fail = 1; code = 2; end
        end
        M_ANALYZE: begin
          if (ad) begin m_res = ar; m_done = 1; m_frames++; nx = M_DONE; end
          else if (expired) begin m_err = 3; nx = M_FAULT; end
        end
        M_DONE:  if (ct || st) begin m_err = 0; m_retry = 0; nx = M_ARM; end
        M_FAULT: if (st) begin m_err = 0; m_retry = 0; nx = M_ARM; end
        default: nx = M_IDLE;
      endcase
    end
    if (fail) begin
      m_err = code;
      if (m_retry < MAX_RETRY) begin m_retry++; nx = M_ARM; end
      else nx = M_FAULT;
    end
    if (nx >= 0) begin m_st = nx; m_cyc = 0; end
  endtask

  task automatic check_outputs();
    chk("cam_init",  bus.cam_init,  32'(m_st == M_CAPTURE));
    chk("an_init",   bus.an_init,   32'(m_st == M_ANALYZE));
    chk("busy",      bus.busy,      32'(m_st == M_ARM || m_st == M_CAPTURE || m_st == M_ANALYZE));
    chk("done",      bus.done,      32'(m_done));
    chk("res",       bus.res,       32'(m_res));
    chk("err_code",  bus.err_code,  32'(m_err));
    chk("frame_cnt", bus.frame_cnt, 32'(m_frames % (1 << CNT_W)));
  endtask

  initial begin
    int pe, pt, pn, pab, prst, r;
    bit cont_mode, prev_ci, prev_ai;
    int cam_lat, cam_kind, cam_hold, an_lat;

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
    bus.cam_done = 1'b0; bus.cam_error = 1'b0; bus.an_done = 1'b0; bus.an_res = 3'd0;
    prev_ci = 0; prev_ai = 0; cam_lat = 0; cam_kind = 0; cam_hold = 0; an_lat = -1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    for (int seg = 0; seg < N_SEG; seg++) begin
      // knobs: cam error %, cam silent %, analyzer silent %, abort per-mille, reset allowed, continuous
      case (seg)
        0:       begin pe = 0;   pt = 0;   pn = 0;   pab = 0;  prst = 0; cont_mode = 0; end
        1:       begin pe = 0;   pt = 0;   pn = 0;   pab = 0;  prst = 0; cont_mode = 1; end
        2:       begin pe = 100; pt = 0;   pn = 0;   pab = 0;  prst = 0; cont_mode = 0; end
        3:       begin pe = 0;   pt = 100; pn = 0;   pab = 0;  prst = 0; cont_mode = 0; end
        4:       begin pe = 0;   pt = 0;   pn = 100; pab = 0;  prst = 0; cont_mode = 0; end
        5:       begin pe = 20;  pt = 10;  pn = 10;  pab = 20; prst = 0; cont_mode = 0; end
        6:       begin pe = 15;  pt = 5;   pn = 5;   pab = 10; prst = 1; cont_mode = 1; end
        default: begin pe = 50;  pt = 5;   pn = 5;   pab = 5;  prst = 1; cont_mode = 0; end
      endcase

      for (int i = 0; i < SEG_LEN; i++) begin
        @(negedge clk);
        check_outputs();

        // Camera: answers after a random latency while cam_init is high, holds status a while after.
        if (m_st == M_CAPTURE) begin
          if (!prev_ci) begin
            cam_lat = $urandom_range(0, 20);
            r = $urandom_range(0, 99);
            if (r < pt) cam_kind = 3;
            else if (r < pt + pe) cam_kind = ($urandom_range(0, 3) == 0) ? 2 : 1;
            else cam_kind = 0;
          end else if (cam_lat > 0) cam_lat--;
          if (cam_lat == 0) begin
            if (cam_kind == 0 || cam_kind == 2) bus.cam_done = 1'b1;
            if (cam_kind == 1 || cam_kind == 2) bus.cam_error = 1'b1;
          end
          prev_ci = 1;
        end else begin
          if (prev_ci) cam_hold = ($urandom_range(0, 99) < 5) ? 60 : int'($urandom_range(0, 8));
          if (cam_hold > 0) cam_hold--;
          else begin bus.cam_done = 1'b0; bus.cam_error = 1'b0; end
          prev_ci = 0;
        end

        // Analyzer: single done pulse with a random result, occasionally a stray pulse when idle.
        bus.an_done = 1'b0;
        if (m_st == M_ANALYZE) begin
          if (!prev_ai) an_lat = ($urandom_range(0, 99) < pn) ? -1 : int'($urandom_range(0, 15));
          if (an_lat == 0) begin
            bus.an_done = 1'b1;
            bus.an_res  = 3'($urandom_range(0, 7));
            an_lat = -1;
          end else if (an_lat > 0) an_lat--;
        end else if ($urandom_range(0, 99) < 2) begin
          bus.an_done = 1'b1;
          bus.an_res  = 3'($urandom_range(0, 7));
        end
        prev_ai = (m_st == M_ANALYZE);

        rst       = (seg == 0 && i < 3) || (prst != 0 && $urandom_range(0, 999) < 2);
        bus.start = ($urandom_range(0, 99) < 8);
        bus.abort = ($urandom_range(0, 999) < pab);
        bus.cont  = cont_mode;

        model_step(rst, bus.start, bus.abort, bus.cont, bus.cam_done, bus.cam_error,
                   bus.an_done, int'(bus.an_res));
      end
    end

    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
